// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//   Single-outstanding load/store responder for the memory stage. A request
//   seen in IDLE is captured, held for LATENCY wait cycles, then the store is
//   committed (byte enables honoured) or the word is read. A one-cycle
//   completion pulse follows on valid_o (plus data_valid_o for loads).
//
// Parameters:
//   ADDR_WIDTH  word-address bits; memory depth is 2**ADDR_WIDTH 32-bit words
//   LATENCY     WAIT cycles between acceptance and response, 0..15
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   request_i      access request (level), sampled only in IDLE
//   we_re_i        1 = store, 0 = load
//   mask_i[3:0]    store byte enables, bit i covers byte i
//   address_i[31:0] byte address; word index = address_i[ADDR_WIDTH+1:2]
//   store_data_i   store write data
//   valid_o        one-cycle completion pulse (loads and stores)
//   data_valid_o   one-cycle pulse with valid_o, loads only
//   load_data_o    last word read; holds between loads
//   busy_o         high whenever the FSM is not IDLE
//   err_o          misaligned-access flag, pulses with valid_o
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, an access with address[1:0] != 0
//                        writes nothing, leaves load_data_o unchanged and
//                        reports err_o=1. When undefined, the low address
//                        bits are ignored and err_o is always 0.
//
// The memory array itself is never reset; its contents survive rst.
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request_i,
  input  logic        we_re_i,
  input  logic [3:0]  mask_i,
  input  logic [31:0] address_i,
  input  logic [31:0] store_data_i,
  output logic        valid_o,
  output logic        data_valid_o,
  output logic [31:0] load_data_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Counter start value when entering WAIT.
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;

  // Captured request
  logic                    we_q;
  logic [3:0]              mask_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [1:0]              off_q;
  logic [31:0]             data_q;

  // Registered outputs
  logic                    valid_q;
  logic                    data_valid_q;
  logic                    err_q;
  logic                    busy_q;

  // Access-side view of the request. With LATENCY=0 the access happens on the
  // accepting edge, so it must use the live inputs; otherwise the access only
  // ever occurs in WAIT and the captured copy is used.
  logic                    access;
  logic                    acc_we;
  logic [3:0]              acc_mask;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [1:0]              acc_off;
  logic [31:0]             acc_data;
  logic                    misal_raw;
  logic                    misal;
  logic                    do_write;
  logic                    do_read;

  always_comb begin
    access   = 1'b0;
    acc_we   = we_q;
    acc_mask = mask_q;
    acc_idx  = idx_q;
    acc_off  = off_q;
    acc_data = data_q;

    if (state_q == ST_IDLE) begin
      acc_we   = we_re_i;
      acc_mask = mask_i;
      acc_idx  = address_i[ADDR_WIDTH+1:2];
      acc_off  = address_i[1:0];
      acc_data = store_data_i;
    end

    if (LATENCY == 0) begin
      access = (state_q == ST_IDLE) && request_i;
    end else begin
      access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    end
  end

  assign misal_raw = (acc_off != 2'b00);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misal = misal_raw;
`else
  logic align_unused;
  assign align_unused = misal_raw;
  assign misal        = 1'b0;
`endif

  // rst is folded in so that an IDLE request seen while reset is held
  // (possible with LATENCY=0) can never commit a write or a read.
  assign do_write = access && acc_we  && !misal && rst;
  assign do_read  = access && !acc_we && !misal && rst;

  // Address bits above the word index are deliberately discarded, giving
  // aliasing modulo the depth.
  generate
    if (ADDR_WIDTH < 30) begin : g_addr_hi
      logic addr_hi_unused;
      assign addr_hi_unused = ^address_i[31:ADDR_WIDTH+2];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      mask_q       <= 4'd0;
      idx_q        <= '0;
      off_q        <= 2'd0;
      data_q       <= 32'd0;
      valid_q      <= 1'b0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses by default.
      valid_q      <= 1'b0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (request_i) begin
            we_q   <= we_re_i;
            mask_q <= mask_i;
            idx_q  <= address_i[ADDR_WIDTH+1:2];
            off_q  <= address_i[1:0];
            data_q <= store_data_i;
            busy_q <= 1'b1;
            if (LATENCY == 0) begin
              state_q      <= ST_RESP;
              valid_q      <= 1'b1;
              data_valid_q <= !we_re_i && !misal;
              err_q        <= misal;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end

        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q      <= ST_RESP;
            valid_q      <= 1'b1;
            data_valid_q <= !we_q && !misal;
            err_q        <= misal;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Storage: one byte-wide array per lane so each byte enable maps onto an
  // independent write port. Each lane keeps its own read register, which
  // also provides the hold-between-loads behaviour of load_data_o.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (do_write && acc_mask[gi]) begin
          mem_q[acc_idx] <= acc_data[8*gi +: 8];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_q <= 8'd0;
        end else if (do_read) begin
          rd_q <= mem_q[acc_idx];
        end
      end

      assign load_data_o[8*gi +: 8] = rd_q;
    end
  endgenerate

  assign valid_o      = valid_q;
  assign data_valid_o = data_valid_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT a: LATENCY=2
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [3:0]  a_mask = 4'h0;
  logic [31:0] a_addr = 32'h0, a_sd = 32'h0;
  logic        a_valid, a_dv, a_busy, a_err;
  logic [31:0] a_ld;

  // DUT b: LATENCY=0
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [3:0]  b_mask = 4'h0;
  logic [31:0] b_addr = 32'h0, b_sd = 32'h0;
  logic        b_valid, b_dv, b_busy, b_err;
  logic [31:0] b_ld;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .request_i(a_req), .we_re_i(a_we), .mask_i(a_mask),
    .address_i(a_addr), .store_data_i(a_sd),
    .valid_o(a_valid), .data_valid_o(a_dv), .load_data_o(a_ld),
    .busy_o(a_busy), .err_o(a_err)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .request_i(b_req), .we_re_i(b_we), .mask_i(b_mask),
    .address_i(b_addr), .store_data_i(b_sd),
    .valid_o(b_valid), .data_valid_o(b_dv), .load_data_o(b_ld),
    .busy_o(b_busy), .err_o(b_err)
  );

  int checks = 0;
  int errors = 0;
  int ntxn   = 0;

  // Reference: word-addressed memory and the value load_data should hold.
  logic [31:0] mdl [1024];
  logic [31:0] exp_ld = 32'h0;

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // One LATENCY=2 transaction on DUT a. Caller is at a falling edge (cycle 0).
  // Expected timing: valid only in cycle 3, busy in cycles 1..3.
  task automatic txn(input logic we, input logic [3:0] m, input logic [31:0] addr,
                     input logic [31:0] d, input bit repulse,
                     output logic [31:0] got_ld, output logic got_dv);
    int          idx;
    bit          misal;
    logic [31:0] e_ld;
    bit          e_dv;
    idx = int'((addr >> 2) & 32'h3FF);
`ifdef DMEM_ALIGN_CHECK_EN
    misal = (addr[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    e_ld = exp_ld;
    e_dv = !we && !misal;
    if (!misal) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (m[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        e_ld = mdl[idx];
      end
    end

    a_req = 1'b1; a_we = we; a_mask = m; a_addr = addr; a_sd = d;
    got_ld = 32'h0; got_dv = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk1($sformatf("busy t%0d k%0d", ntxn, k), a_busy, (k <= 3));
      chk1($sformatf("valid t%0d k%0d", ntxn, k), a_valid, (k == 3));
      if (k == 3) begin
        got_ld = a_ld;
        got_dv = a_dv;
        chk1($sformatf("data_valid t%0d", ntxn), a_dv, e_dv);
        chk1($sformatf("err t%0d", ntxn), a_err, misal);
        chk32($sformatf("load_data t%0d", ntxn), a_ld, e_ld);
      end
      if (repulse && k <= 2) begin
        a_req = 1'b1; a_we = 1'b1; a_sd = ~d;
      end else begin
        a_req = 1'b0;
      end
    end
    exp_ld = e_ld;
    $display("txn %0d we=%0d mask=%h addr=%08h data=%08h repulse=%0d -> ld=%08h dv=%0d",
             ntxn, we, m, addr, d, repulse, got_ld, got_dv);
    ntxn++;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  m;
    logic [31:0] addr;
    logic [31:0] d;
    bit          repulse;
    logic [31:0] exp_ld;
    logic        exp_dv;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] got;
    logic        gdv;
    logic [31:0] ra;

    tbl[0] = '{1'b1, 4'hF, 32'h00000010, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
    tbl[1] = '{1'b0, 4'h0, 32'h00000010, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b1};
    tbl[2] = '{1'b1, 4'h2, 32'h00000010, 32'h0000AA00, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b0, 4'hF, 32'h00000010, 32'h00000000, 1'b0, 32'hDEADAAEF, 1'b1};
    tbl[4] = '{1'b1, 4'hF, 32'h00000020, 32'hCAFEF00D, 1'b0, 32'hDEADAAEF, 1'b0};
    tbl[5] = '{1'b0, 4'h0, 32'h00000020, 32'h55555555, 1'b1, 32'hCAFEF00D, 1'b1};
    tbl[6] = '{1'b0, 4'h0, 32'h00000020, 32'h00000000, 1'b0, 32'hCAFEF00D, 1'b1};
    tbl[7] = '{1'b0, 4'h0, 32'h00001010, 32'h00000000, 1'b0, 32'hDEADAAEF, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst a_valid", a_valid, 1'b0);
    chk1("rst a_busy", a_busy, 1'b0);
    chk32("rst a_ld", a_ld, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int v = 0; v < 8; v++) begin
      txn(tbl[v].we, tbl[v].m, tbl[v].addr, tbl[v].d, tbl[v].repulse, got, gdv);
      chk32($sformatf("vec%0d ld", v), got, tbl[v].exp_ld);
      chk1($sformatf("vec%0d dv", v), gdv, tbl[v].exp_dv);
    end

    // Reset in cycle 1 of a store to 0x20 (holds 0xCAFEF00D)
    a_req = 1'b1; a_we = 1'b1; a_mask = 4'hF; a_addr = 32'h20; a_sd = 32'h12345678;
    @(negedge clk);
    a_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk1("rstmid a_valid", a_valid, 1'b0);
    chk1("rstmid a_dv", a_dv, 1'b0);
    chk1("rstmid a_busy", a_busy, 1'b0);
    chk1("rstmid a_err", a_err, 1'b0);
    chk32("rstmid a_ld", a_ld, 32'h0);
    chk1("rstmid b_valid", b_valid, 1'b0);
    chk1("rstmid b_busy", b_busy, 1'b0);
    chk32("rstmid b_ld", b_ld, 32'h0);
    rst = 1'b1;
    exp_ld = 32'h0;
    @(negedge clk);
    txn(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, got, gdv);
    chk32("rst keeps mem", got, 32'hCAFEF00D);

    // Misaligned store to 0x22, then read word 0x20
    txn(1'b1, 4'hF, 32'h22, 32'h11111111, 1'b0, got, gdv);
    txn(1'b0, 4'h0, 32'h20, 32'h0, 1'b0, got, gdv);
`ifdef DMEM_ALIGN_CHECK_EN
    chk32("misaligned store", got, 32'hCAFEF00D);
`else
    chk32("misaligned store", got, 32'h11111111);
`endif

    // LATENCY=0 on DUT b: a store, then loads with request held for 4 cycles
    b_req = 1'b1; b_we = 1'b1; b_mask = 4'hF; b_addr = 32'h10; b_sd = 32'h0BADF00D;
    @(negedge clk);
    chk1("l0 store valid", b_valid, 1'b1);
    chk1("l0 store dv", b_dv, 1'b0);
    b_req = 1'b0;
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_mask = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk1($sformatf("l0 valid k%0d", k), b_valid, (k == 1 || k == 3));
      chk1($sformatf("l0 busy k%0d", k), b_busy, (k == 1 || k == 3));
      if (k == 1 || k == 3) begin
        chk1($sformatf("l0 dv k%0d", k), b_dv, 1'b1);
        chk32($sformatf("l0 ld k%0d", k), b_ld, 32'h0BADF00D);
      end
      if (k == 4) b_req = 1'b0;
    end
    $display("txn l0 load burst addr=00000010 ld=%08h", b_ld);

    // Randomized: prefill 8 words, then mixed traffic with aliasing and offsets
    for (int i = 0; i < 8; i++) begin
      txn(1'b1, 4'hF, {20'h0, 10'h40 + 10'(i), 2'b00}, $urandom, 1'b0, got, gdv);
    end
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      ra = {ra[31:12], 10'h40 + 10'($urandom_range(0, 7)), ra[1:0]};
      txn(1'($urandom_range(0, 1)), 4'($urandom), ra, $urandom,
          ($urandom_range(0, 3) == 0), got, gdv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
